// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller for the mriscv core: latches requests,
// applies mask and fixed priority, and drives the vector/return addresses.
module irq_ctrl #(
  parameter int unsigned N_IRQ      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  localparam int unsigned IW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             enable_pc,
  input  logic [31:0]      pc,
  input  logic [11:0]      opcode,
  output logic             irr,
  output logic [31:0]      irr_dest,
  output logic [31:0]      irr_ret,
  output logic             irq_active,
  output logic [IW-1:0]    irq_id,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam logic [6:0]  OP_BXX    = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [11:0] OP_RETIRQ = 12'b001110011000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] req_d;
  logic [N_IRQ-1:0] pending, pending_nxt;
  logic [N_IRQ-1:0] set_vec, clr_vec, sel;
  logic [N_IRQ-1:0] ack_nxt;
  logic [IW-1:0]    win;
  logic [IW-1:0]    id_nxt;
  logic [31:0]      dest_nxt, ret_nxt;
  logic             eligible, retirq;

  always_comb begin
    set_vec = irq_req & ~req_d;
    sel     = pending & irq_mask;

    // Scan from the top so the lowest selectable index is written last and wins.
    win = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (sel[N_IRQ-1-i]) win = IW'(N_IRQ - 1 - i);
    end

    eligible = enable_pc &&
               (opcode[6:0] != OP_BXX) &&
               (opcode[6:0] != OP_JAL) &&
               (opcode[6:0] != OP_JALR) &&
               (opcode != OP_RETIRQ);
    retirq   = enable_pc && (opcode == OP_RETIRQ);

    state_nxt = state;
    id_nxt    = irq_id;
    dest_nxt  = irr_dest;
    ret_nxt   = irr_ret;
    clr_vec   = '0;
    ack_nxt   = '0;

    case (state)
      IDLE: begin
        if (sel != '0) begin
          id_nxt    = win;
          dest_nxt  = VEC_BASE + 32'(win) * VEC_STRIDE;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (eligible) begin
          ret_nxt         = pc + 32'd4;
          clr_vec[irq_id] = 1'b1;
          ack_nxt[irq_id] = 1'b1;
          state_nxt       = SERVICE;
        end
      end
      SERVICE: begin
        if (retirq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A new edge on the line being cleared in the same cycle keeps it pending.
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_d      <= '0;
      pending    <= '0;
      irr        <= 1'b0;
      irq_active <= 1'b0;
      irq_ack    <= '0;
      irq_id     <= '0;
      irr_dest   <= VEC_BASE;
      irr_ret    <= '0;
    end else begin
      state      <= state_nxt;
      req_d      <= irq_req;
      pending    <= pending_nxt;
      irr        <= (state_nxt == PEND);
      irq_active <= (state_nxt == SERVICE);
      irq_ack    <= ack_nxt;
      irq_id     <= id_nxt;
      irr_dest   <= dest_nxt;
      irr_ret    <= ret_nxt;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

  localparam logic [11:0] OP_ADD    = 12'h033;
  localparam logic [11:0] OP_LUI    = 12'h037;
  localparam logic [11:0] OP_JAL    = 12'h06F;
  localparam logic [11:0] OP_BEQ    = 12'h063;
  localparam logic [11:0] OP_JALR   = 12'h067;
  localparam logic [11:0] OP_RETIRQ = 12'b001110011000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_req;
  logic [7:0]  irq_mask;
  logic        enable_pc;
  logic [31:0] pc;
  logic [11:0] opcode;
  logic        irr;
  logic [31:0] irr_dest;
  logic [31:0] irr_ret;
  logic        irq_active;
  logic [2:0]  irq_id;
  logic [7:0]  irq_ack;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(.N_IRQ(8), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'h10)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_req    (irq_req),
    .irq_mask   (irq_mask),
    .enable_pc  (enable_pc),
    .pc         (pc),
    .opcode     (opcode),
    .irr        (irr),
    .irr_dest   (irr_dest),
    .irr_ret    (irr_ret),
    .irq_active (irq_active),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [11:0] op, input logic [31:0] addr);
    enable_pc = 1'b1;
    opcode    = op;
    pc        = addr;
    step();
    enable_pc = 1'b0;
    opcode    = OP_ADD;
  endtask

  initial begin
    rst = 1'b0; irq_req = '0; irq_mask = 8'hFF;
    enable_pc = 1'b0; pc = '0; opcode = OP_ADD;
    step(); step();
    check("rst_irr",    32'(irr),        32'd0);
    check("rst_active", 32'(irq_active), 32'd0);
    check("rst_ack",    32'(irq_ack),    32'd0);
    check("rst_id",     32'(irq_id),     32'd0);
    check("rst_dest",   irr_dest,        32'h100);
    check("rst_ret",    irr_ret,         32'h0);
    rst = 1'b1;
    step();

    // Single request on line 3
    irq_req = 8'h08; step();
    check("t1_irr_k", 32'(irr), 32'd0);
    irq_req = 8'h00; step();
    check("t1_irr",  32'(irr),    32'd1);
    check("t1_id",   32'(irq_id), 32'd3);
    check("t1_dest", irr_dest,    32'h130);
    commit(OP_ADD, 32'h40);
    check("t1_take_irr", 32'(irr),        32'd0);
    check("t1_active",   32'(irq_active), 32'd1);
    check("t1_ack",      32'(irq_ack),    32'h08);
    check("t1_ret",      irr_ret,         32'h44);
    step();
    check("t1_ack_drop", 32'(irq_ack),    32'h00);
    check("t1_active2",  32'(irq_active), 32'd1);
    commit(OP_RETIRQ, 32'h80);
    check("t1_ret_act", 32'(irq_active), 32'd0);
    check("t1_ret_irr", 32'(irr),        32'd0);

    // Lines 5 and 2 together: 2 first, then 5 without a new edge
    irq_req = 8'h24; step();
    irq_req = 8'h00; step();
    check("t2_id_a",   32'(irq_id), 32'd2);
    check("t2_dest_a", irr_dest,    32'h120);
    commit(OP_ADD, 32'h100);
    check("t2_ack_a", 32'(irq_ack), 32'h04);
    check("t2_ret_a", irr_ret,      32'h104);
    commit(OP_RETIRQ, 32'h120);
    check("t2_idle_irr", 32'(irr), 32'd0);
    step();
    check("t2_irr_b",  32'(irr),    32'd1);
    check("t2_id_b",   32'(irq_id), 32'd5);
    check("t2_dest_b", irr_dest,    32'h150);
    commit(OP_ADD, 32'h200);
    check("t2_ack_b", 32'(irq_ack), 32'h20);
    check("t2_ret_b", irr_ret,      32'h204);
    commit(OP_RETIRQ, 32'h220);
    step();

    // Control transfers cannot take the interrupt
    irq_req = 8'h40; step();
    irq_req = 8'h00; step();
    check("t3_irr",  32'(irr),    32'd1);
    check("t3_dest", irr_dest,    32'h160);
    commit(OP_JAL, 32'h300);
    check("t3_jal_irr", 32'(irr), 32'd1);
    check("t3_jal_ret", irr_ret,  32'h204);
    commit(OP_BEQ, 32'h304);
    check("t3_beq_irr", 32'(irr), 32'd1);
    commit(OP_RETIRQ, 32'h308);
    check("t3_rti_irr", 32'(irr),        32'd1);
    check("t3_rti_act", 32'(irq_active), 32'd0);
    commit(OP_JALR, 32'h30C);
    check("t3_jalr_irr", 32'(irr), 32'd1);
    commit(OP_LUI, 32'h310);
    check("t3_lui_irr", 32'(irr),        32'd0);
    check("t3_lui_act", 32'(irq_active), 32'd1);
    check("t3_lui_ret", irr_ret,         32'h314);
    check("t3_lui_ack", 32'(irq_ack),    32'h40);
    commit(OP_RETIRQ, 32'h340);
    step();

    // Masked line stays pending until unmasked
    irq_mask = 8'hFD;
    irq_req = 8'h02; step();
    irq_req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_masked_irr", 32'(irr), 32'd0);
    end
    irq_mask = 8'hFF; step();
    check("t4_irr",  32'(irr),    32'd1);
    check("t4_id",   32'(irq_id), 32'd1);
    check("t4_dest", irr_dest,    32'h110);
    commit(OP_ADD, 32'h400);
    check("t4_ack", 32'(irq_ack), 32'h02);
    check("t4_ret", irr_ret,      32'h404);

    // No nesting: request during service waits for RETIRQ
    irq_req = 8'h01; step();
    irq_req = 8'h00; step(); step();
    check("t5_svc_irr", 32'(irr),        32'd0);
    check("t5_svc_act", 32'(irq_active), 32'd1);
    commit(OP_RETIRQ, 32'h500);
    check("t5_rti_irr", 32'(irr),        32'd0);
    check("t5_rti_act", 32'(irq_active), 32'd0);
    step();
    check("t5_irr",  32'(irr),    32'd1);
    check("t5_id",   32'(irq_id), 32'd0);
    check("t5_dest", irr_dest,    32'h100);
    check("t5_ret_hold", irr_ret, 32'h404);
    commit(OP_ADD, 32'h600);
    check("t5_ret_new", irr_ret,      32'h604);
    check("t5_ack",     32'(irq_ack), 32'h01);

    // Reset in SERVICE with line 4 pending
    irq_req = 8'h10; step();
    irq_req = 8'h00; step();
    rst = 1'b0; step();
    check("t6_irr",    32'(irr),        32'd0);
    check("t6_active", 32'(irq_active), 32'd0);
    check("t6_ack",    32'(irq_ack),    32'd0);
    check("t6_id",     32'(irq_id),     32'd0);
    check("t6_dest",   irr_dest,        32'h100);
    check("t6_ret",    irr_ret,         32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_irr", 32'(irr), 32'd0);
    end
    irq_req = 8'h10; step();
    irq_req = 8'h00; step();
    check("t6_irr_new", 32'(irr),    32'd1);
    check("t6_id_new",  32'(irq_id), 32'd4);
    check("t6_dest_new", irr_dest,   32'h140);

    // Edge on the line being taken in the same cycle keeps it pending
    irq_req = 8'h10;
    commit(OP_ADD, 32'h700);
    irq_req = 8'h00;
    check("t7_ack", 32'(irq_ack), 32'h10);
    check("t7_ret", irr_ret,      32'h704);
    commit(OP_RETIRQ, 32'h720);
    step();
    check("t7_irr", 32'(irr),    32'd1);
    check("t7_id",  32'(irq_id), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the mriscv core, sitting beside the PC/CSR utility unit. It latches edge-triggered interrupt requests, applies a mask and fixed priority, and drives `irr`/`irr_dest` so the utility's next-PC mux vectors to a handler. It captures the return address on the same commit and serves it on `irr_ret` for `RETIRQ`. There is one nesting level: no preemption while a handler runs.

## Interface
- `N_IRQ`, default 8: number of request lines, 1..16.
- `VEC_BASE`, default 32'h0000_0100: vector address of line 0.
- `VEC_STRIDE`, default 32'h10: byte distance between consecutive vectors.

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-low reset, sampled on `posedge clk`.
- `irq_req`  in  N_IRQ  request lines. A rising edge marks a line pending.
- `irq_mask`  in  N_IRQ  1 = line enabled.
- `enable_pc`  in  1  the core commits a PC update this cycle.
- `pc`  in  32  current PC (address of the committing instruction).
- `opcode`  in  12  decoded opcode of the committing instruction (same encoding as the utility unit).
- `irr`  out  1  interrupt take request to the utility unit.
- `irr_dest`  out  32  handler address.
- `irr_ret`  out  32  saved return address.
- `irq_active`  out  1  a handler is in service.
- `irq_id`  out  $clog2(N_IRQ) (min 1)  ID of the latched or serviced line.
- `irq_ack`  out  N_IRQ  one-hot, single-cycle pulse when an interrupt is taken.

## Operation
- Edge detect: a registered copy `req_d` is kept. A bit of `pending` is set when `irq_req & ~req_d` is 1 on that bit. Setting happens regardless of the mask.
- Selectable set: `pending & irq_mask`. The lowest index has the highest priority.
- Eligible commit: `enable_pc=1` and `opcode` is not a control transfer:
  - `opcode[6:0]` is not 1100011 (BXX), 1101111 (JAL) or 1100111 (JALR);
  - `opcode` is not 12'b001110011000 (RETIRQ).
- State machine, states IDLE, PEND, SERVICE:
  - IDLE: if the selectable set is nonzero, latch the winner into `irq_id`, load `irr_dest` = VEC_BASE + id*VEC_STRIDE (32-bit wrap), then go to PEND.
  - PEND: `irr`=1. The latched ID is frozen; a higher-priority arrival or a later mask drop does not change it. On an eligible commit:
    - `irr_ret` <= `pc`+4 (32-bit wrap);
    - clear `pending[irq_id]`;
    - pulse `irq_ack[irq_id]` on the next cycle;
    - go to SERVICE.
    - A non-eligible commit or `enable_pc=0` keeps the state in PEND.
  - SERVICE: `irq_active`=1, `irr`=0, `irr_ret` held stable. A commit with `enable_pc=1` and `opcode`=RETIRQ returns the state to IDLE.
- A RETIRQ outside SERVICE is ignored by this block.
- A rising edge on a line that is already pending is absorbed (no counting).
- A rising edge on the line being taken, in the same cycle as the take, leaves that bit pending.
- If set and clear hit the same bit in the same cycle, set wins.

## Timing
- Reset (`rst`=0 at an edge) forces all outputs and internal state to defaults, taking priority over everything, including mid-PEND or mid-SERVICE:
  - state = IDLE; `pending`, `req_d` = 0;
  - `irr`, `irq_active`, `irq_ack` = 0;
  - `irq_id` = 0; `irr_dest` = VEC_BASE; `irr_ret` = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency:
  - `irq_req` rises at edge k → `pending` set after edge k;
  - state enters PEND and `irr`=1 after edge k+1, when the line is masked in and the state is IDLE.
- Take: the eligible commit is sampled at edge t. The utility loads `irr_dest` at that same edge because `irr`=1 during cycle t. After edge t: `irr`=0, `irq_active`=1, `irq_ack` high for exactly one cycle.
- Return: RETIRQ committed at edge r. After edge r: `irq_active`=0. If another line is selectable, `irr` rises after edge r+1.
- `irr_dest` and `irq_id` change only on the IDLE→PEND transition and at reset.

## Test plan
- Reset, then pulse `irq_req[3]`=1 with mask 8'hFF → after 2 edges `irr`=1, `irq_id`=3, `irr_dest`=32'h130. Commit an ADD at `pc`=32'h40 → `irr_ret`=32'h44, `irq_ack`=8'h08 for one cycle, `irq_active`=1.
- Raise lines 5 and 2 in the same cycle → line 2 is taken first (`irr_dest`=32'h120). After RETIRQ, line 5 is taken (`irr_dest`=32'h150) with no new edge required.
- In PEND, commit JAL, then BEQ, then RETIRQ → `irr` stays 1 and the state stays PEND. A following LUI commit takes the interrupt with `irr_ret` = that PC+4.
- Mask line 1 off, pulse it → no `irr`. Unmask 10 cycles later → `irr`=1 one cycle after the unmask edge, with `irq_id`=1.
- In SERVICE, pulse line 0 → no `irr` until RETIRQ commits. Then `irr` rises after the next edge and `irr_ret` is replaced only on the new take.
- Assert `rst`=0 while in SERVICE with line 4 pending → all outputs at reset values after the edge, `pending` cleared, and no `irr` until a fresh rising edge.
